// File: rtl/runway_light_ctrl_if.sv
// Signal bundle between the runway light sequencer and its surroundings.
// master: the sequencer (samples wind switches/enable, drives the pattern FSM).
// slave : the surroundings (switch inputs, pattern FSM, status observer).
// Optional macro RUNWAY_STEP_CNT_EN adds step_count [15:0].
interface runway_light_ctrl_if;
  logic [1:0]  wind_raw;
  logic        enable;
  logic [1:0]  lights_w;
  logic        lights_reset;
  logic        step;
  logic [1:0]  wind_stable;
  logic        change;
`ifdef RUNWAY_STEP_CNT_EN
  logic [15:0] step_count;

  modport master (
    input  wind_raw, enable,
    output lights_w, lights_reset, step, wind_stable, change, step_count
  );
  modport slave (
    output wind_raw, enable,
    input  lights_w, lights_reset, step, wind_stable, change, step_count
  );
`else
  modport master (
    input  wind_raw, enable,
    output lights_w, lights_reset, step, wind_stable, change
  );
  modport slave (
    output wind_raw, enable,
    input  lights_w, lights_reset, step, wind_stable, change
  );
`endif
endinterface

// File: rtl/runway_light_ctrl.sv
// Runway light sequencer: synchronizes and debounces the wind switches,
// divides clk into a step rate, and feeds the pattern FSM one wind code per
// step (hold code 2'b11 otherwise). The pattern is restarted on start-up and
// whenever the debounced wind code changes.
// Optional macro RUNWAY_STEP_CNT_EN adds a saturating step counter output.
module runway_light_ctrl #(
  parameter int TICK_DIV   = 8,
  parameter int DEB_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  runway_light_ctrl_if.master bus
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RESTART = 2'd1;
  localparam logic [1:0] RUN     = 2'd2;

  localparam logic [1:0] HOLD_CODE = 2'b11;

  logic [1:0]    raw_ok;
  logic [1:0]    sync_d, sync_q;
  logic [1:0]    cand, stable;
  logic [DW-1:0] cnt;
  logic          change_q;
  logic [1:0]    state, state_nxt;
  logic [PW-1:0] pre;
  logic          tick, step_w;

  // 2'b11 from the switches is not a legal wind code; treat it as calm.
  assign raw_ok = (bus.wind_raw == 2'b11) ? 2'b00 : bus.wind_raw;

  // Two-flop synchronizer for the asynchronous switches.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_d <= 2'b00;
      sync_q <= 2'b00;
    end else begin
      sync_d <= raw_ok;
      sync_q <= sync_d;
    end
  end

  // Debounce: commit a code once it has been seen DEB_CYCLES times in a row;
  // change pulses only when the committed value actually moves.
  always_ff @(posedge clk) begin
    if (reset) begin
      cand     <= 2'b00;
      cnt      <= '0;
      stable   <= 2'b00;
      change_q <= 1'b0;
    end else if (sync_q != cand) begin
      cand     <= sync_q;
      cnt      <= '0;
      change_q <= 1'b0;
    end else if (cnt == DEB_LAST) begin
      stable   <= cand;
      change_q <= (cand != stable);
    end else begin
      cnt      <= cnt + DW'(1);
      change_q <= 1'b0;
    end
  end

  // Next-state decode; enable loss beats a wind change, which beats running on.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = bus.enable ? RESTART : IDLE;
      RESTART: state_nxt = bus.enable ? RUN : IDLE;
      RUN: begin
        if (!bus.enable)   state_nxt = IDLE;
        else if (change_q) state_nxt = RESTART;
        else               state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Step prescaler: counts only while staying in RUN, parked at 0 otherwise
  // so the first step lands on the TICK_DIV-th RUN cycle.
  always_ff @(posedge clk) begin
    if (reset)
      pre <= '0;
    else if (state == RUN && state_nxt == RUN)
      pre <= (pre == PRE_LAST) ? '0 : pre + PW'(1);
    else
      pre <= '0;
  end

  assign tick   = (state == RUN) && (pre == PRE_LAST);
  assign step_w = tick && !change_q && bus.enable;

  assign bus.step         = step_w;
  assign bus.lights_w     = step_w ? stable : HOLD_CODE;
  assign bus.lights_reset = (state != RUN);
  assign bus.wind_stable  = stable;
  assign bus.change       = change_q;

`ifdef RUNWAY_STEP_CNT_EN
  logic [15:0] step_cnt;

  // Lifetime step counter; saturates, and only reset clears it.
  always_ff @(posedge clk) begin
    if (reset)
      step_cnt <= 16'h0000;
    else if (step_w && step_cnt != 16'hFFFF)
      step_cnt <= step_cnt + 16'd1;
  end

  assign bus.step_count = step_cnt;
`endif

endmodule
